// File: rtl/systolic_output_collector.sv
// systolic_output_collector
//   Gathers the result words draining from the bottom of the systolic array
//   and assembles them into a ROWS x COLS output matrix. For columns that BISR
//   has flagged faulty, the weight-proxy path supplies the results instead.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | after reset; valids ignored, waiting for start
//   COLLECT | capturing words per column until every column holds ROWS
//   DONE    | matrix complete and held; valids ignored until next start
//
// Ports
//   clk                  clock, rising edge
//   rst                  asynchronous active-low reset
//   start                one-cycle pulse, clears capture state, enters COLLECT
//   faulty_col_mask      per column: 1 = take results from the proxy path
//   bottom_out_bus       array column outputs, column c at [c*WORD_SIZE +: WORD_SIZE]
//   output_col_valid     per-column qualifier for bottom_out_bus
//   proxy_output_bus     proxy results, same packing as bottom_out_bus
//   proxy_out_valid_bus  per-column qualifier for proxy_output_bus
//   output_matrix        entry (r,c) at [(r*COLS+c)*WORD_SIZE +: WORD_SIZE]
//   matmul_in_progress   high in COLLECT
//   matmul_output_done   high in DONE
//   overflow_err         sticky; selected valid seen on an already-full column
module systolic_output_collector #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COLS-1:0]                faulty_col_mask,
  input  logic [COLS*WORD_SIZE-1:0]      bottom_out_bus,
  input  logic [COLS-1:0]                output_col_valid,
  input  logic [COLS*WORD_SIZE-1:0]      proxy_output_bus,
  input  logic [COLS-1:0]                proxy_out_valid_bus,
  output logic [ROWS*COLS*WORD_SIZE-1:0] output_matrix,
  output logic                           matmul_in_progress,
  output logic                           matmul_output_done,
  output logic                           overflow_err
);

  localparam int CW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] FULL = CW'(ROWS);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q [COLS];
  logic [CW-1:0]                  cnt_d [COLS];
  logic [ROWS*COLS*WORD_SIZE-1:0] mat_q, mat_d;
  logic                           ovf_q, ovf_d;

  logic [COLS-1:0]                sel_valid;
  logic [WORD_SIZE-1:0]           sel_data [COLS];
  logic                           all_full;

  // Per-column source mux; the non-selected source is ignored entirely.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      sel_valid[c] = faulty_col_mask[c] ? proxy_out_valid_bus[c] : output_col_valid[c];
      sel_data[c]  = faulty_col_mask[c] ? proxy_output_bus[c*WORD_SIZE +: WORD_SIZE]
                                        : bottom_out_bus[c*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_comb begin
    state_d  = state_q;
    mat_d    = mat_q;
    ovf_d    = ovf_q;
    all_full = 1'b0;
    for (int c = 0; c < COLS; c++) cnt_d[c] = cnt_q[c];

    if (start) begin
      // start wins in every state; valids in this cycle are dropped.
      state_d = COLLECT;
      mat_d   = '0;
      ovf_d   = 1'b0;
      for (int c = 0; c < COLS; c++) cnt_d[c] = '0;
    end else if (state_q == COLLECT) begin
      for (int c = 0; c < COLS; c++) begin
        if (sel_valid[c]) begin
          if (cnt_q[c] < FULL) begin
            for (int r = 0; r < ROWS; r++) begin
              if (cnt_q[c] == CW'(r)) mat_d[(r*COLS+c)*WORD_SIZE +: WORD_SIZE] = sel_data[c];
            end
            cnt_d[c] = cnt_q[c] + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      // Look at next-state counters so the finishing edge itself enters DONE.
      all_full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        if (cnt_d[c] != FULL) all_full = 1'b0;
      end
      if (all_full) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      ovf_q   <= 1'b0;
      for (int c = 0; c < COLS; c++) cnt_q[c] <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      ovf_q   <= ovf_d;
      for (int c = 0; c < COLS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign output_matrix      = mat_q;
  assign matmul_in_progress = (state_q == COLLECT);
  assign matmul_output_done = (state_q == DONE);
  assign overflow_err       = ovf_q;

endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
- Downstream of the weight-stationary systolic array. Captures per-column result words as they drain from bottom_out_bus and assembles them into a full ROWS x COLS output matrix.
- For columns flagged faulty by BISR, the weight-proxy path supplies the column's results instead of the array.
- Raises done once every column has delivered ROWS results. Feeds the top-level output_matrix and matmul_output_done.

Parameters:
- ROWS, 4, rows in the result matrix (entries per column).
- COLS, 4, columns in the array and result matrix.
- WORD_SIZE, 16, bits per result word.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears capture state and begins a new collection.
- faulty_col_mask  in  COLS  bit c=1: column c results come from the proxy path; held stable during collection.
- bottom_out_bus  in  COLS*WORD_SIZE  array column outputs; column c at [c*WORD_SIZE +: WORD_SIZE].
- output_col_valid  in  COLS  bit c qualifies column c of bottom_out_bus this cycle.
- proxy_output_bus  in  COLS*WORD_SIZE  proxy results, same packing.
- proxy_out_valid_bus  in  COLS  bit c qualifies column c of proxy_output_bus.
- output_matrix  out  ROWS*COLS*WORD_SIZE  entry (r,c) at [(r*COLS+c)*WORD_SIZE +: WORD_SIZE].
- matmul_in_progress  out  1  high in COLLECT.
- matmul_output_done  out  1  high in DONE.
- overflow_err  out  1  sticky; an accepted-source valid arrived for a column already holding ROWS entries.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; output_matrix all zero; all row counters 0.
  - matmul_in_progress=0, matmul_output_done=0, overflow_err=0.
- States:
  - IDLE: valids ignored; start -> COLLECT.
  - COLLECT: capture active; when all columns are full -> DONE.
  - DONE: matrix held; valids ignored; start -> COLLECT.
- start:
  - In any state, at that edge: counters cleared, overflow_err cleared, state=COLLECT.
  - output_matrix is zeroed at the same edge.
  - Valids sampled in the start cycle are ignored.
  - start during COLLECT aborts and restarts collection.
- Source selection per column c: sel_valid = faulty_col_mask[c] ? proxy_out_valid_bus[c] : output_col_valid[c]; data is taken from the matching bus. The non-selected source is ignored entirely.
- Capture in COLLECT:
  - If sel_valid and cnt[c] < ROWS: write entry (cnt[c], c) and increment cnt[c].
  - Columns are independent; any subset may be valid in the same cycle.
  - Latency: the written entry is visible on output_matrix the cycle after the valid is sampled.
- Counters: width $clog2(ROWS+1); saturate at ROWS and never wrap.
- Overflow: sel_valid with cnt[c]==ROWS in COLLECT sets overflow_err; the data is dropped and the stored matrix is unchanged.
- Completion:
  - The edge that makes every cnt[c]==ROWS, including when several columns finish together, moves the state to DONE.
  - matmul_output_done rises in the same cycle the final entry becomes visible.
  - Valids arriving in DONE are ignored and do not set overflow_err.
- Mask change mid-collection: already-captured entries are kept; subsequent captures use the new mask.
- Reset mid-collection: immediate return to reset values; no partial matrix survives.
- No arithmetic is performed; words are passed through unmodified at full WORD_SIZE.

Test Plan:
- Reset/idle: rst=0 then 1, no start, drive output_col_valid=4'b1111 with data 5 for 3 cycles -> output_matrix all 0, both status outputs 0, overflow_err 0.
- Skewed drain, no faults (4x4): start, then column c valid on cycles c..c+3, value = 10*r+c -> entry (r,c)=10*r+c. matmul_output_done rises the cycle after column 3's last valid; matmul_in_progress falls the same cycle.
- Proxy substitution: faulty_col_mask=4'b0100; array drives 999 on column 2 with valid; proxy drives 7,8,9,10 with proxy_out_valid_bus[2] -> column 2 = {7,8,9,10}, 999 never stored, done only after the 4th proxy word.
- Overflow: after column 0 holds 4 entries (others incomplete), one extra column 0 valid with data 55 -> overflow_err=1, column 0 unchanged. Next start -> overflow_err=0 and matrix zeroed.
- Restart mid-collection: start, 2 rows captured in all columns, start again, then full 4-row drain of value 3 -> every entry 3, done asserted exactly once.
- Async reset mid-collection: rst low between clock edges during COLLECT -> outputs zero immediately, without waiting for a clk edge; after release, valids without start are ignored.
